// File: rtl/audio_pkg.sv
// Shared definitions for the audio-in side of Audio_Controller.
// - pop_state_e : states of the sample-pop handshake FSM
// - SAMPLE_W    : width of one signed two's-complement audio sample
// - SAMPLE_RATE_HZ, THRESH_DEFAULT : sample rate and default Schmitt threshold
// - abs_sat()   : magnitude of a signed sample, with -2^31 clamped to 2^31-1
package audio_pkg;

  localparam int SAMPLE_W       = 32;
  localparam int SAMPLE_RATE_HZ = 48000;

  localparam logic signed [SAMPLE_W-1:0] THRESH_DEFAULT = 32'sd20000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PROC = 2'd2
  } pop_state_e;

  // The most negative sample has no positive counterpart in SAMPLE_W bits,
  // so it is clamped to the largest positive value.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] r;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      r = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (s[SAMPLE_W-1]) begin
      r = SAMPLE_W'(-s);
    end else begin
      r = SAMPLE_W'(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/schmitt_period_meter.sv
// Hysteresis zero-crossing detector and tone-period matcher.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   proc_en       : high for one cycle when 'sample' holds a new sample to process
//   sample        : signed sample being processed
//   crossing      : high during proc_en when the sample makes a rising Schmitt crossing
//   tone_valid    : registered; MATCH_N consecutive matching periods seen
//   tone_period   : last accepted period, loaded when the match count reaches MATCH_N
module schmitt_period_meter
  import audio_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] THRESH = THRESH_DEFAULT,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 2048,
  parameter int TOL        = 2,
  parameter int MATCH_N    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       proc_en,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       crossing,
  output logic                       tone_valid,
  output logic [15:0]                tone_period
);

  localparam int MW = $clog2(MATCH_N + 1);
  localparam logic [15:0]   CNT_SAT   = 16'(MAX_PERIOD + 1);
  localparam logic [15:0]   P_MIN     = 16'(MIN_PERIOD);
  localparam logic [15:0]   P_MAX     = 16'(MAX_PERIOD);
  localparam logic [15:0]   P_TOL     = 16'(TOL);
  localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_N);

  logic          pol_q, pol_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   last_q, last_d;
  logic [MW-1:0] match_q, match_d;
  logic          valid_q, valid_d;
  logic [15:0]   period_q, period_d;

  logic          rise;
  logic          in_range;
  logic [15:0]   diff;

  always_comb begin
    pol_d    = pol_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    match_d  = match_q;
    valid_d  = valid_q;
    period_d = period_q;
    in_range = 1'b0;
    diff     = 16'd0;
    rise     = proc_en && !pol_q && (sample > THRESH);

    if (proc_en) begin
      cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + 16'd1;

      if (!pol_q && (sample > THRESH)) begin
        pol_d = 1'b1;
      end else if (pol_q && (sample < -THRESH)) begin
        pol_d = 1'b0;
      end

      // Saturated count means no crossing for longer than MAX_PERIOD: silence.
      if (cnt_q >= CNT_SAT) begin
        match_d = '0;
      end

      if (rise) begin
        // cnt_q is the number of samples since the previous crossing.
        in_range = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
        diff     = (cnt_q >= last_q) ? (cnt_q - last_q) : (last_q - cnt_q);
        if (in_range && (diff <= P_TOL)) begin
          match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MW'(1);
        end else if (in_range) begin
          match_d = MW'(1);
        end else begin
          match_d = '0;
        end
        last_d = cnt_q;
        cnt_d  = 16'd1;
        if (match_d == MATCH_MAX) begin
          period_d = cnt_q;
        end
      end

      valid_d = (match_d == MATCH_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pol_q    <= 1'b0;
      cnt_q    <= 16'd0;
      last_q   <= 16'd0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      period_q <= 16'd0;
    end else begin
      pol_q    <= pol_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      period_q <= period_d;
    end
  end

  assign crossing    = rise;
  assign tone_valid  = valid_q;
  assign tone_period = period_q;

endmodule

// File: rtl/mic_tone_detector.sv
// Microphone tone detector: pops left-channel samples from the audio-in FIFO,
// measures tone period with a Schmitt zero-crossing meter and tracks the
// windowed peak amplitude.
// Ports:
//   CLOCK_50, reset            : clock, synchronous active-high reset
//   enable                     : low = no new pops, detector state holds
//   audio_in_available         : FIFO holds at least one sample
//   left_channel_audio_in      : signed sample at the FIFO head
//   read_audio_in              : one-cycle pop strobe
//   crossing                   : one-cycle pulse on each rising Schmitt crossing
//   tone_valid, tone_period    : stable-tone flag and last accepted period
//   peak_level, level_strobe   : max |sample| of last full window, update pulse
// Handshake: a sample is taken when audio_in_available is high in IDLE; the
// value at the FIFO head is captured in that cycle and read_audio_in pulses in
// the following cycle to pop it. Pops are therefore at least 3 cycles apart.
module mic_tone_detector
  import audio_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] THRESH = THRESH_DEFAULT,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 2048,
  parameter int TOL        = 2,
  parameter int MATCH_N    = 4,
  parameter int WINDOW     = 4800
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  output logic                read_audio_in,
  output logic                crossing,
  output logic                tone_valid,
  output logic [15:0]         tone_period,
  output logic [SAMPLE_W-1:0] peak_level,
  output logic                level_strobe
);

  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [WW-1:0] W_END = WW'(WINDOW);

  pop_state_e                 state_q, state_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       read_q, read_d;
  logic [SAMPLE_W-1:0]        run_peak_q, run_peak_d;
  logic [SAMPLE_W-1:0]        peak_q, peak_d;
  logic                       strobe_q, strobe_d;
  logic [WW-1:0]              wcnt_q, wcnt_d;

  logic [SAMPLE_W-1:0]        abs_v;
  logic [SAMPLE_W-1:0]        peak_max;
  logic [WW-1:0]              wcnt_next;
  logic                       proc_en;

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    read_d     = 1'b0;
    run_peak_d = run_peak_q;
    peak_d     = peak_q;
    strobe_d   = 1'b0;
    wcnt_d     = wcnt_q;
    abs_v      = abs_sat(sample_q);
    peak_max   = (abs_v > run_peak_q) ? abs_v : run_peak_q;
    wcnt_next  = wcnt_q + WW'(1);

    case (state_q)
      ST_IDLE: begin
        if (enable && audio_in_available) begin
          sample_d = $signed(left_channel_audio_in);
          read_d   = 1'b1;
          state_d  = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_PROC;
      end
      ST_PROC: begin
        state_d = ST_IDLE;
        // The sample ending the window still counts toward that window's peak.
        if (wcnt_next == W_END) begin
          peak_d     = peak_max;
          run_peak_d = '0;
          wcnt_d     = '0;
          strobe_d   = 1'b1;
        end else begin
          run_peak_d = peak_max;
          wcnt_d     = wcnt_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sample_q   <= '0;
      read_q     <= 1'b0;
      run_peak_q <= '0;
      peak_q     <= '0;
      strobe_q   <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      read_q     <= read_d;
      run_peak_q <= run_peak_d;
      peak_q     <= peak_d;
      strobe_q   <= strobe_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign proc_en = (state_q == ST_PROC);

  schmitt_period_meter #(
    .THRESH     (THRESH),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD),
    .TOL        (TOL),
    .MATCH_N    (MATCH_N)
  ) u_meter (
    .clk         (CLOCK_50),
    .reset       (reset),
    .proc_en     (proc_en),
    .sample      (sample_q),
    .crossing    (crossing),
    .tone_valid  (tone_valid),
    .tone_period (tone_period)
  );

  // Reset overrides a pending pop even in the cycle it is asserted, so the
  // FIFO never loses a sample to a sequence that reset abandons.
  assign read_audio_in = read_q && !reset;
  assign peak_level    = peak_q;
  assign level_strobe  = strobe_q;

endmodule

// File: tb/tb_mic_tone_detector.sv
module tb_mic_tone_detector;

  localparam logic [31:0] POS = 32'd100000000;
  localparam logic [31:0] NEG = 32'hFA0A1F00; // -100000000

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        avail = 1'b0;
  logic [31:0] din = 32'd0;
  logic        read_audio_in, crossing, tone_valid, level_strobe;
  logic [15:0] tone_period;
  logic [31:0] peak_level;

  mic_tone_detector dut (
    .CLOCK_50              (clk),
    .reset                 (reset),
    .enable                (enable),
    .audio_in_available    (avail),
    .left_channel_audio_in (din),
    .read_audio_in         (read_audio_in),
    .crossing              (crossing),
    .tone_valid            (tone_valid),
    .tone_period           (tone_period),
    .peak_level            (peak_level),
    .level_strobe          (level_strobe)
  );

  // scoreboard counters
  int   n_cmp = 0;
  int   n_err = 0;
  int   cross_cnt = 0;
  int   strobe_cnt = 0;
  logic cross_seen = 1'b0;
  logic strobe_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset  = 1'b1;
    avail  = 1'b0;
    din    = 32'd0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    reset      = 1'b0;
    cross_cnt  = 0;
    strobe_cnt = 0;
  endtask

  // Called at a negedge with the FSM in IDLE; returns at the next IDLE negedge
  // with crossing (sampled in PROC) and level_strobe (sampled after PROC) recorded.
  task automatic send_sample(input logic [31:0] v);
    logic got;
    got   = 1'b0;
    din   = v;
    avail = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = read_audio_in;
    end
    if (!got) begin
      check_eq("pop_timeout", {31'd0, read_audio_in}, 32'd1);
      cross_seen  = 1'b0;
      strobe_seen = 1'b0;
    end else begin
      @(negedge clk);
      cross_seen = crossing;
      if (crossing) cross_cnt++;
      @(negedge clk);
      strobe_seen = level_strobe;
      if (level_strobe) strobe_cnt++;
    end
  endtask

  initial begin
    int   reads, viol, gap_err, last_idx, pre_strobes;
    logic prev, valid_seen, got;
    logic [31:0] exp_max;

    // reset state
    do_reset();
    check_eq("rst_read", {31'd0, read_audio_in}, 32'd0);
    check_eq("rst_crossing", {31'd0, crossing}, 32'd0);
    check_eq("rst_tone_valid", {31'd0, tone_valid}, 32'd0);
    check_eq("rst_tone_period", {16'd0, tone_period}, 32'd0);
    check_eq("rst_peak_level", peak_level, 32'd0);
    check_eq("rst_level_strobe", {31'd0, level_strobe}, 32'd0);

    // square wave, period 48: crossings at pops 1,49,97,145,193
    for (int n = 0; n < 193; n++) begin
      send_sample(((n % 48) < 24) ? POS : NEG);
      if (n == 144) begin
        check_eq("sq_cross_4", cross_cnt, 32'd4);
        check_eq("sq_valid_at_4th", {31'd0, tone_valid}, 32'd0);
      end
    end
    check_eq("sq_cross_5", cross_cnt, 32'd5);
    check_eq("sq_valid_at_5th", {31'd0, tone_valid}, 32'd1);
    check_eq("sq_period", {16'd0, tone_period}, 32'd48);

    // silence: tone_valid holds through pop 2048, drops at pop 2049
    cross_cnt = 0;
    for (int k = 1; k <= 2049; k++) begin
      send_sample(32'd0);
      if (k == 2048) check_eq("to_valid_2048", {31'd0, tone_valid}, 32'd1);
      if (k == 2049) check_eq("to_valid_2049", {31'd0, tone_valid}, 32'd0);
    end
    check_eq("to_period_hold", {16'd0, tone_period}, 32'd48);
    check_eq("to_no_cross", cross_cnt, 32'd0);

    // alternating crossing intervals 52/48: never a stable tone
    cross_cnt  = 0;
    valid_seen = 1'b0;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < (((p % 2) == 0) ? 24 : 28); i++) begin
        send_sample(NEG);
        valid_seen |= tone_valid;
      end
      for (int i = 0; i < 24; i++) begin
        send_sample(POS);
        valid_seen |= tone_valid;
      end
    end
    check_eq("alt_cross", cross_cnt, 32'd8);
    check_eq("alt_valid_seen", {31'd0, valid_seen}, 32'd0);
    check_eq("alt_no_strobe", strobe_cnt, 32'd0);

    // handshake spacing: 10 pops, 3 cycles apart, then none with enable low
    do_reset();
    avail    = 1'b1;
    reads    = 0;
    viol     = 0;
    gap_err  = 0;
    last_idx = -1;
    prev     = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (read_audio_in) begin
        reads++;
        if (prev) viol++;
        if (last_idx >= 0 && (i - last_idx) != 3) gap_err++;
        last_idx = i;
      end
      prev = read_audio_in;
    end
    avail = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (read_audio_in) reads++;
    end
    check_eq("hs_pop_count", reads, 32'd10);
    check_eq("hs_back_to_back", viol, 32'd0);
    check_eq("hs_gap", gap_err, 32'd0);
    enable = 1'b0;
    avail  = 1'b1;
    reads  = 0;
    repeat (12) begin
      @(negedge clk);
      if (read_audio_in) reads++;
    end
    check_eq("hs_disabled_pops", reads, 32'd0);
    avail  = 1'b0;
    enable = 1'b1;

    // noise inside the hysteresis band for one full window
    do_reset();
    exp_max     = 32'd0;
    pre_strobes = 0;
    for (int n = 0; n < 4800; n++) begin
      int s;
      int a;
      s = ((n * 7919) % 38000001) - 19000000;
      a = (s < 0) ? -s : s;
      if (32'(a) > exp_max) exp_max = 32'(a);
      send_sample(32'(s));
      if (n < 4799 && strobe_seen) pre_strobes++;
    end
    check_eq("nz_strobe_end", {31'd0, strobe_seen}, 32'd1);
    check_eq("nz_strobe_early", pre_strobes, 32'd0);
    check_eq("nz_peak", peak_level, exp_max);
    check_eq("nz_peak_bound", {31'd0, (peak_level <= 32'd19000000)}, 32'd1);
    check_eq("nz_no_cross", cross_cnt, 32'd0);
    check_eq("nz_valid", {31'd0, tone_valid}, 32'd0);

    // most negative sample saturates to the largest magnitude
    do_reset();
    send_sample(32'h80000000);
    for (int n = 1; n < 4800; n++) send_sample(32'd0);
    check_eq("min_strobe_end", {31'd0, strobe_seen}, 32'd1);
    check_eq("min_strobe_cnt", strobe_cnt, 32'd1);
    check_eq("min_peak", peak_level, 32'd2147483647);
    check_eq("min_no_cross", cross_cnt, 32'd0);

    // crossing and window end on the same sample; last sample sets the peak
    do_reset();
    for (int n = 0; n < 4799; n++) send_sample(32'd0);
    check_eq("co_no_early_strobe", strobe_cnt, 32'd0);
    send_sample(POS);
    check_eq("co_cross", {31'd0, cross_seen}, 32'd1);
    check_eq("co_strobe", {31'd0, strobe_seen}, 32'd1);
    check_eq("co_peak", peak_level, POS);

    // reset asserted during POP
    enable = 1'b1;
    din    = 32'd0;
    avail  = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = read_audio_in;
    end
    check_eq("rp_pop_seen", {31'd0, got}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rp_read_in_reset", {31'd0, read_audio_in}, 32'd0);
    @(negedge clk);
    check_eq("rp_read_next", {31'd0, read_audio_in}, 32'd0);
    check_eq("rp_crossing", {31'd0, crossing}, 32'd0);
    check_eq("rp_tone_valid", {31'd0, tone_valid}, 32'd0);
    check_eq("rp_tone_period", {16'd0, tone_period}, 32'd0);
    check_eq("rp_peak_level", peak_level, 32'd0);
    check_eq("rp_level_strobe", {31'd0, level_strobe}, 32'd0);
    avail = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
